// File: rtl/wb_commit_pkg.sv
// wb_commit_pkg: shared types and constants for the writeback/commit stage.
// Provides the RUN/FLUSH state enum, lsu_op load encodings, exception
// ecodes and the etype-bit -> exception-info lookup.
package wb_commit_pkg;

    typedef enum logic {RUN, FLUSH} state_e;

    localparam logic [3:0] LSU_B  = 4'b0000;
    localparam logic [3:0] LSU_H  = 4'b0001;
    localparam logic [3:0] LSU_W  = 4'b0010;
    localparam logic [3:0] LSU_BU = 4'b1000;
    localparam logic [3:0] LSU_HU = 4'b1001;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_PIL  = 6'h01;
    localparam logic [5:0] ECODE_PIS  = 6'h02;
    localparam logic [5:0] ECODE_PIF  = 6'h03;
    localparam logic [5:0] ECODE_PME  = 6'h04;
    localparam logic [5:0] ECODE_PPI  = 6'h07;
    localparam logic [5:0] ECODE_ADE  = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;
    localparam logic [5:0] ECODE_BRK  = 6'h0C;
    localparam logic [5:0] ECODE_INE  = 6'h0D;
    localparam logic [5:0] ECODE_IPE  = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    // Where the reported bad virtual address comes from.
    typedef enum logic [1:0] {BV_NONE, BV_PC, BV_BADV} badv_src_e;

    typedef struct packed {
        logic [5:0] ecode;
        logic [8:0] esub;
        badv_src_e  src;
        logic       tlb;
    } exc_info_t;

    // Exception info for etype bit b (b is the lowest set bit, i.e. the winner).
    function automatic exc_info_t exc_info(input logic [3:0] b);
        case (b)
            4'd0:    return '{ECODE_INT,  9'd0, BV_NONE, 1'b0};
            4'd1:    return '{ECODE_ADE,  9'd0, BV_PC,   1'b0};
            4'd2:    return '{ECODE_TLBR, 9'd0, BV_PC,   1'b1};
            4'd3:    return '{ECODE_PIF,  9'd0, BV_PC,   1'b1};
            4'd4:    return '{ECODE_PPI,  9'd0, BV_PC,   1'b1};
            4'd5:    return '{ECODE_SYS,  9'd0, BV_NONE, 1'b0};
            4'd6:    return '{ECODE_BRK,  9'd0, BV_NONE, 1'b0};
            4'd7:    return '{ECODE_INE,  9'd0, BV_NONE, 1'b0};
            4'd8:    return '{ECODE_IPE,  9'd0, BV_NONE, 1'b0};
            4'd9:    return '{ECODE_ALE,  9'd0, BV_BADV, 1'b0};
            4'd10:   return '{ECODE_ADE,  9'd1, BV_BADV, 1'b0};
            4'd11:   return '{ECODE_TLBR, 9'd0, BV_BADV, 1'b1};
            4'd12:   return '{ECODE_PME,  9'd0, BV_BADV, 1'b1};
            4'd13:   return '{ECODE_PPI,  9'd0, BV_BADV, 1'b1};
            4'd14:   return '{ECODE_PIS,  9'd0, BV_BADV, 1'b1};
            default: return '{ECODE_PIL,  9'd0, BV_BADV, 1'b1};
        endcase
    endfunction

endpackage

// File: rtl/wb_load_align.sv
// wb_load_align: combinational load-data alignment and extension for one lane.
// Ports: ram_rd_data_i (raw memory word), rw_data_i (bits [1:0] = byte offset,
// also the fallback result), lsu_op_i (load type), data_o (aligned result).
module wb_load_align
    import wb_commit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] ram_rd_data_i,
    input  logic [DATA_W-1:0] rw_data_i,
    input  logic [3:0]        lsu_op_i,
    output logic [DATA_W-1:0] data_o
);

    logic [DATA_W-1:0] sh;

    assign sh = ram_rd_data_i >> {rw_data_i[1:0], 3'b000};

    always_comb
        data_o = lsu_op_i == LSU_W  ? sh :
                 lsu_op_i == LSU_B  ? {{(DATA_W-8){sh[7]}}, sh[7:0]} :
                 lsu_op_i == LSU_H  ? {{(DATA_W-16){sh[15]}}, sh[15:0]} :
                 lsu_op_i == LSU_BU ? {{(DATA_W-8){1'b0}}, sh[7:0]} :
                 lsu_op_i == LSU_HU ? {{(DATA_W-16){1'b0}}, sh[15:0]} :
                 rw_data_i;

endmodule

// File: rtl/wb_commit_stage.sv
// wb_commit_stage: registers a commit bundle, writes back lanes older than the
// first trapping lane, reports the trap (exception or ertn) and discards
// bundles for FLUSH_CYCLES cycles afterwards.
// Ports: clk/rst_n; in_valid_i/in_ready_o handshake; per-lane bundle inputs
// (pc, writeback, load info, etype, badv, is_ertn, ram data); per-lane
// register-file writes and debug pc; exception/ertn report and flush pulse.
module wb_commit_stage
    import wb_commit_pkg::*;
#(
    parameter int LANES        = 2,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int REG_W        = 5,
    parameter int ETYPE_W      = 16,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [LANES-1:0][ADDR_W-1:0]      in_pc_i,
    input  logic [LANES-1:0]                  in_rw_en_i,
    input  logic [LANES-1:0][REG_W-1:0]       in_rw_addr_i,
    input  logic [LANES-1:0][DATA_W-1:0]      in_rw_data_i,
    input  logic [LANES-1:0]                  in_ram_rd_en_i,
    input  logic [LANES-1:0][3:0]             in_lsu_op_i,
    input  logic [LANES-1:0][ETYPE_W-1:0]     in_etype_i,
    input  logic [LANES-1:0][ADDR_W-1:0]      in_badv_i,
    input  logic [LANES-1:0]                  in_is_ertn_i,
    input  logic [LANES-1:0][DATA_W-1:0]      ram_rd_data_i,
    output logic [LANES-1:0]                  rf_we_o,
    output logic [LANES-1:0][REG_W-1:0]       rf_waddr_o,
    output logic [LANES-1:0][DATA_W-1:0]      rf_wdata_o,
    output logic [LANES-1:0][ADDR_W-1:0]      dbg_pc_o,
    output logic                              exc_valid_o,
    output logic [5:0]                        exc_ecode_o,
    output logic [8:0]                        exc_esubcode_o,
    output logic [ADDR_W-1:0]                 exc_pc_o,
    output logic                              exc_badv_valid_o,
    output logic [ADDR_W-1:0]                 exc_badv_o,
    output logic                              exc_tlb_o,
    output logic [18:0]                       exc_tlb_vppn_o,
    output logic                              ertn_valid_o,
    output logic                              flush_o
);

    localparam int CNT_W = FLUSH_CYCLES > 1 ? $clog2(FLUSH_CYCLES) : 1;
    localparam int KW    = LANES > 1 ? $clog2(LANES) : 1;
    localparam int NB    = ETYPE_W < 16 ? ETYPE_W : 16;

    typedef struct packed {
        logic [LANES-1:0]             we;
        logic [LANES-1:0][REG_W-1:0]  waddr;
        logic [LANES-1:0][DATA_W-1:0] wdata;
        logic [LANES-1:0][ADDR_W-1:0] pc;
        logic                         exc;
        logic [5:0]                   ecode;
        logic [8:0]                   esub;
        logic [ADDR_W-1:0]            epc;
        logic                         bv;
        logic [ADDR_W-1:0]            badv;
        logic                         tlb;
        logic [18:0]                  vppn;
        logic                         ertn;
        logic                         flush;
    } out_t;

    state_e                      state_q;
    logic [CNT_W-1:0]            cnt_q;
    out_t                        out_d, out_q;
    logic                        live, blocked, trap;
    logic [KW-1:0]               k;
    logic [ETYPE_W-1:0]          sel_etype;
    logic [3:0]                  bsel;
    exc_info_t                   info;
    logic [ADDR_W-1:0]           sel_badv;
    logic [LANES-1:0][DATA_W-1:0] ld_data;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        wb_load_align #(.DATA_W(DATA_W)) u_align (
            .ram_rd_data_i (ram_rd_data_i[l]),
            .rw_data_i     (in_rw_data_i[l]),
            .lsu_op_i      (in_lsu_op_i[l]),
            .data_o        (ld_data[l])
        );
    end

    assign in_ready_o = state_q == RUN || state_q == FLUSH;
    // Bundles accepted during the flush window are swallowed here.
    assign live = in_valid_i && in_ready_o && state_q == RUN;

    always_comb begin
        out_d   = '0;
        blocked = 1'b0;
        k       = '0;
        for (int i = 0; i < LANES; i++) begin
            trap = in_etype_i[i] != '0 || in_is_ertn_i[i];
            if (trap && !blocked) k = KW'(i);
            // blocked covers the trapping lane itself and every younger lane
            blocked           = blocked | trap;
            out_d.we[i]       = in_rw_en_i[i] && !blocked;
            out_d.waddr[i]    = in_rw_addr_i[i];
            out_d.wdata[i]    = in_ram_rd_en_i[i] ? ld_data[i] : in_rw_data_i[i];
            out_d.pc[i]       = in_pc_i[i];
        end
        sel_etype = in_etype_i[k];
        bsel      = '0;
        for (int b = NB - 1; b >= 0; b--)
            if (sel_etype[b]) bsel = 4'(b);
        info       = exc_info(bsel);
        sel_badv   = info.src == BV_PC ? in_pc_i[k] : info.src == BV_BADV ? in_badv_i[k] : '0;
        out_d.exc  = blocked && sel_etype != '0;
        out_d.ertn = blocked && sel_etype == '0;
        out_d.flush = blocked;
        out_d.epc   = blocked ? in_pc_i[k] : '0;
        out_d.ecode = out_d.exc ? info.ecode : '0;
        out_d.esub  = out_d.exc ? info.esub : '0;
        out_d.bv    = out_d.exc && info.src != BV_NONE;
        out_d.badv  = out_d.exc ? sel_badv : '0;
        out_d.tlb   = out_d.exc && info.tlb;
        out_d.vppn  = out_d.tlb ? sel_badv[31:13] : '0;
        if (!live) out_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            out_q <= out_d;
            if (out_d.flush) begin
                state_q <= FLUSH;
                cnt_q   <= CNT_W'(FLUSH_CYCLES - 1);
            end else if (state_q == FLUSH) begin
                if (cnt_q == '0) state_q <= RUN;
                else cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign rf_we_o          = out_q.we;
    assign rf_waddr_o       = out_q.waddr;
    assign rf_wdata_o       = out_q.wdata;
    assign dbg_pc_o         = out_q.pc;
    assign exc_valid_o      = out_q.exc;
    assign exc_ecode_o      = out_q.ecode;
    assign exc_esubcode_o   = out_q.esub;
    assign exc_pc_o         = out_q.epc;
    assign exc_badv_valid_o = out_q.bv;
    assign exc_badv_o       = out_q.badv;
    assign exc_tlb_o        = out_q.tlb;
    assign exc_tlb_vppn_o   = out_q.vppn;
    assign ertn_valid_o     = out_q.ertn;
    assign flush_o          = out_q.flush;

endmodule
